// File: rtl/vie_mem_arb_pkg.sv
// ============================================================================
//  Module   : vie_mem_arb_pkg
//  Purpose  : Shared encodings for the inst/data memory-port arbiter.
//             - transfer size encoding (byte / half / word)
//             - owner encoding (VIE_ARB_INST / VIE_ARB_DATA)
//             - arbiter state encoding
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vie_mem_arb_pkg;

    // Transfer size as carried on the SRAM-like ports
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    // Owner encoding of the memory port
    localparam logic VIE_ARB_INST = 1'b0;
    localparam logic VIE_ARB_DATA = 1'b1;

    // Arbiter states
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,   // no transaction, grant computed combinationally
        ARB_ADDR = 2'd1,   // request issued, waiting for mem_addr_ok
        ARB_WAIT = 2'd2    // address accepted, waiting for mem_data_ok
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/vie_arb_grant.sv
// ============================================================================
//  Module   : vie_arb_grant
//  Purpose  : Combinational grant selection between fetch and data masters.
//             Fixed priority (data over inst) by default; round-robin when
//             VIE_ARB_RR_EN is defined.
//  Ports    : inst_req_i, data_req_i   request lines
//             rr_last_i                last granted owner (VIE_ARB_RR_EN only)
//             grant_valid_o            some master is requesting
//             grant_owner_o            selected owner (VIE_ARB_INST/DATA)
//  Config   : VIE_ARB_RR_EN
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vie_arb_grant
    import vie_mem_arb_pkg::*;
(
`ifdef VIE_ARB_RR_EN
    input  logic rr_last_i,
`endif
    input  logic inst_req_i,
    input  logic data_req_i,
    output logic grant_valid_o,
    output logic grant_owner_o
);

    always_comb begin
        grant_valid_o = inst_req_i | data_req_i;
        grant_owner_o = VIE_ARB_INST;
        if (inst_req_i && data_req_i) begin
`ifdef VIE_ARB_RR_EN
            // Contention: hand the port to whoever was not served last
            grant_owner_o = ~rr_last_i;
`else
            grant_owner_o = VIE_ARB_DATA;
`endif
        end else if (data_req_i) begin
            grant_owner_o = VIE_ARB_DATA;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vie_mem_arb.sv
// ============================================================================
//  Module   : vie_mem_arb
//  Purpose  : Shares the single SRAM-like memory port (toward the AXI bridge)
//             between the fetch stage and the data path. One outstanding
//             transaction; grant locked from request to data return; fetch
//             data made stale by a pipeline flush is dropped.
//  Ports    : clock, reset (sync, active-high), flush_i
//             inst_*  fetch port   (read-only, word size)
//             data_*  data port    (load/store, byte/half/word)
//             mem_*   bridge port
//             arb_busy  state != IDLE
//  Config   : VIE_ARB_RR_EN  round-robin on contention (else data > inst)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vie_mem_arb
    import vie_mem_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush_i,
    // fetch port
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // bridge port
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_busy
);

    arb_state_e state_q, state_d;
    logic       owner_q;
    logic       discard_q, discard_d;

    logic       grant_valid;
    logic       grant_owner;
    logic       sel_owner;     // master currently steering the mem_* mux
    logic       sel_data;
    logic       ret_valid;     // data return accepted this cycle

    // ------------------------------------------------------------------
    // Grant policy
    // ------------------------------------------------------------------
`ifdef VIE_ARB_RR_EN
    logic rr_last_q;

    vie_arb_grant u_grant (
        .rr_last_i     (rr_last_q),
        .inst_req_i    (inst_req),
        .data_req_i    (data_req),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );
`else
    vie_arb_grant u_grant (
        .inst_req_i    (inst_req),
        .data_req_i    (data_req),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );
`endif

    // ------------------------------------------------------------------
    // Next state, mux select and request
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sel_owner = owner_q;
        mem_req   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                sel_owner = grant_owner;
                mem_req   = grant_valid;
                if (grant_valid && mem_addr_ok) begin
                    state_d = ARB_WAIT;
                end else if (grant_valid) begin
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                // Locked to the owner even if the other master now requests
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_data_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign sel_data  = (sel_owner == VIE_ARB_DATA);
    assign ret_valid = (state_q == ARB_WAIT) && mem_data_ok;

    // Payload is forced to zero whenever no request is presented so the
    // bridge side is quiet while both requesters are idle.
    assign mem_wr    = mem_req & sel_data & data_wr;
    assign mem_size  = !mem_req ? 2'b00 : (sel_data ? data_size : SIZE_WORD);
    assign mem_addr  = !mem_req ? 32'h0 : (sel_data ? data_addr : inst_addr);
    assign mem_wdata = (mem_req && sel_data) ? data_wdata : 32'h0;

    // mem_req is already low in WAIT, so address handshakes vanish there
    assign inst_addr_ok = mem_req & ~sel_data & mem_addr_ok;
    assign data_addr_ok = mem_req &  sel_data & mem_addr_ok;

    // A flush in the return cycle kills the fetch data just like an earlier
    // flush recorded in discard_q; data-owner returns are never suppressed.
    assign inst_data_ok = ret_valid & (owner_q == VIE_ARB_INST) & ~discard_q & ~flush_i;
    assign data_data_ok = ret_valid & (owner_q == VIE_ARB_DATA);

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;
    assign arb_busy   = (state_q != ARB_IDLE);

    // ------------------------------------------------------------------
    // Stale-fetch tracking
    // ------------------------------------------------------------------
    always_comb begin
        discard_d = discard_q;
        if (ret_valid) begin
            discard_d = 1'b0;
        end else if (flush_i && !sel_data && (state_q != ARB_IDLE || mem_req)) begin
            discard_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= VIE_ARB_INST;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (mem_req) begin
                owner_q <= sel_owner;
            end
        end
    end

`ifdef VIE_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_q <= VIE_ARB_INST;
        end else if (mem_req && mem_addr_ok) begin
            rr_last_q <= sel_owner;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vie_mem_arb.sv
// ============================================================================
//  Module   : tb_vie_mem_arb
//  Purpose  : Self-checking bench for vie_mem_arb: directed scenarios plus a
//             randomized run checked against a transaction-level model.
//  Config   : VIE_ARB_RR_EN  selects the round-robin expectation
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vie_mem_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        arb_busy;

    int n_pass  = 0;
    int n_total = 0;

    vie_mem_arb dut (
        .clock        (clock),
        .reset        (reset),
        .flush_i      (flush_i),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .arb_busy     (arb_busy)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction record
    //   m_busy  : a master owns the port (granted, not yet returned)
    //   m_acc   : its address has been accepted by the bridge
    //   m_owner : 0 fetch, 1 data
    //   m_stale : fetch data must be dropped
    // ------------------------------------------------------------------
    logic m_busy  = 1'b0;
    logic m_acc   = 1'b0;
    logic m_owner = 1'b0;
    logic m_stale = 1'b0;
`ifdef VIE_ARB_RR_EN
    logic m_last  = 1'b0;
`endif

    function automatic logic pick(input logic i, input logic d);
        if (i && d) begin
`ifdef VIE_ARB_RR_EN
            return ~m_last;
`else
            return 1'b1;
`endif
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Check all outputs at the falling edge, then advance the model.
    task automatic eval();
        logic exp_req, who, ret;
        @(negedge clock);
        if (!m_busy) begin
            exp_req = inst_req | data_req;
            who     = pick(inst_req, data_req);
        end else begin
            exp_req = ~m_acc;
            who     = m_owner;
        end
        ret = m_busy & m_acc & mem_data_ok;

        chk("mem_req",      {31'h0, mem_req},      {31'h0, exp_req});
        chk("inst_addr_ok", {31'h0, inst_addr_ok}, {31'h0, exp_req & ~who & mem_addr_ok});
        chk("data_addr_ok", {31'h0, data_addr_ok}, {31'h0, exp_req &  who & mem_addr_ok});
        chk("inst_data_ok", {31'h0, inst_data_ok}, {31'h0, ret & ~m_owner & ~m_stale & ~flush_i});
        chk("data_data_ok", {31'h0, data_data_ok}, {31'h0, ret & m_owner});
        chk("inst_rdata",   inst_rdata, mem_rdata);
        chk("data_rdata",   data_rdata, mem_rdata);
        chk("arb_busy",     {31'h0, arb_busy},     {31'h0, m_busy});
        if (exp_req) begin
            chk("mem_addr", mem_addr, who ? data_addr : inst_addr);
            chk("mem_wr",   {31'h0, mem_wr}, {31'h0, who & data_wr});
            chk("mem_size", {30'h0, mem_size}, {30'h0, (who ? data_size : 2'b10)});
            if (who) chk("mem_wdata", mem_wdata, data_wdata);
        end else if (!m_busy) begin
            chk("idle_addr", mem_addr, 32'h0);
            chk("idle_size", {30'h0, mem_size}, 32'h0);
            chk("idle_wr",   {31'h0, mem_wr}, 32'h0);
        end

        if (reset) begin
            m_busy = 1'b0; m_acc = 1'b0; m_owner = 1'b0; m_stale = 1'b0;
`ifdef VIE_ARB_RR_EN
            m_last = 1'b0;
`endif
        end else if (m_busy && m_acc) begin
            if (mem_data_ok) begin
                m_busy = 1'b0; m_acc = 1'b0; m_stale = 1'b0;
            end else if (flush_i && !m_owner) begin
                m_stale = 1'b1;
            end
        end else if (exp_req) begin
            m_busy  = 1'b1;
            m_owner = who;
            m_acc   = mem_addr_ok;
            if (flush_i && !who) m_stale = 1'b1;
`ifdef VIE_ARB_RR_EN
            if (mem_addr_ok) m_last = who;
`endif
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        eval();
        adv();
    endtask

    task automatic quiet();
        reset = 0; flush_i = 0; inst_req = 0; data_req = 0; data_wr = 0;
        mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    initial begin
        logic first_data;
        reset = 1; flush_i = 0;
        inst_req = 0; inst_addr = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
        tick(); tick();
        reset = 0;
        tick();
        chk("reset_busy", {31'h0, arb_busy}, 32'h0);

        // ---- single fetch: addr_ok cycle 0, data_ok cycle 3 ----
        inst_req = 1; inst_addr = 32'hBFC00000; mem_addr_ok = 1;
        eval();
        chk("t1_iaok", {31'h0, inst_addr_ok}, 32'h1);
        chk("t1_addr", mem_addr, 32'hBFC00000);
        adv();
        quiet();
        tick(); tick();
        mem_data_ok = 1; mem_rdata = 32'h3C1D0000;
        eval();
        chk("t1_idok", {31'h0, inst_data_ok}, 32'h1);
        chk("t1_data", inst_rdata, 32'h3C1D0000);
        adv();
        quiet();
        eval();
        chk("t1_idle", {31'h0, arb_busy}, 32'h0);
        adv();

        // ---- simultaneous fetch and load ----
        first_data = pick(1'b1, 1'b1);
        inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_addr = 32'h80000010; data_size = 2'd2; mem_addr_ok = 1;
        eval();
        chk("t2_first", {31'h0, data_addr_ok}, {31'h0, first_data});
        adv();
        if (first_data) data_req = 0; else inst_req = 0;
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11112222;
        eval();
        chk("t2_no_second_in_wait", {31'h0, inst_addr_ok | data_addr_ok}, 32'h0);
        adv();
        mem_data_ok = 0; mem_addr_ok = 1;
        eval();
        chk("t2_second", {31'h0, first_data ? inst_addr_ok : data_addr_ok}, 32'h1);
        adv();
        quiet();
        mem_data_ok = 1;
        tick();
        quiet();
        tick();

        // ---- store with delayed address accept, fetch rises meanwhile ----
        data_req = 1; data_wr = 1; data_size = 2'd2;
        data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) inst_req = 1;
            mem_addr_ok = (c == 4);
            eval();
            chk("t3_wdata", mem_wdata, 32'hDEADBEEF);
            chk("t3_wr", {31'h0, mem_wr}, 32'h1);
            chk("t3_iaok", {31'h0, inst_addr_ok}, 32'h0);
            adv();
        end
        data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 1;
        eval();
        chk("t3_ddok", {31'h0, data_data_ok}, 32'h1);
        adv();

        // ---- fetch flushed while waiting ----
        mem_data_ok = 0; mem_addr_ok = 1; inst_addr = 32'hBFC00100;
        tick();
        quiet();
        flush_i = 1;
        tick();
        flush_i = 0;
        tick();
        mem_data_ok = 1; mem_rdata = 32'hBAD0BAD0;
        eval();
        chk("t4_suppressed", {31'h0, inst_data_ok}, 32'h0);
        adv();
        quiet();
        inst_req = 1; inst_addr = 32'hBFC00200; mem_addr_ok = 1;
        eval();
        chk("t4_regrant", {31'h0, inst_addr_ok}, 32'h1);
        adv();
        quiet();
        mem_data_ok = 1; mem_rdata = 32'h00C0FFEE;
        eval();
        chk("t4_fresh", {31'h0, inst_data_ok}, 32'h1);
        adv();

        // ---- flush on the return cycle of a load ----
        quiet();
        data_req = 1; data_size = 2'd0; data_addr = 32'h80002003; mem_addr_ok = 1;
        tick();
        quiet();
        flush_i = 1; mem_data_ok = 1; mem_rdata = 32'h12345678;
        eval();
        chk("t5_ddok", {31'h0, data_data_ok}, 32'h1);
        chk("t5_data", data_rdata, 32'h12345678);
        adv();

        // ---- reset while waiting ----
        quiet();
        inst_req = 1; mem_addr_ok = 1;
        tick();
        quiet();
        reset = 1;
        tick();
        reset = 0; mem_data_ok = 1;
        eval();
        chk("t6_busy", {31'h0, arb_busy}, 32'h0);
        chk("t6_no_dok", {31'h0, inst_data_ok | data_data_ok}, 32'h0);
        adv();

        // ---- randomized traffic ----
        for (int n = 0; n < 2000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            flush_i     = ($urandom_range(0, 7) == 0);
            inst_req    = ($urandom_range(0, 2) != 0);
            data_req    = ($urandom_range(0, 2) == 0);
            data_wr     = $urandom_range(0, 1) == 1;
            data_size   = 2'($urandom_range(0, 2));
            inst_addr   = $urandom;
            data_addr   = $urandom;
            data_wdata  = $urandom;
            mem_addr_ok = ($urandom_range(0, 2) != 0);
            mem_data_ok = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vie_mem_arb.md
# vie_mem_arb

Two-master SRAM-like arbiter sharing the single CPU-side memory port (toward the AXI bridge) between the fetch stage and the data path that feeds the memory stage's load/store results. Allows exactly one outstanding transaction, keeps the grant locked from request to data return, and discards fetch data made stale by a pipeline flush. It sits between the pipeline's inst/data SRAM-like ports and the AXI bridge.

## Interface
- No parameters; widths come from the shared defines.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- flush_i  in  1  pipeline flush (flushbus taken bit)
- inst_req / inst_addr  in  1 / 32  fetch request, read-only, size fixed 2'b10
- inst_addr_ok / inst_data_ok  out  1 / 1  fetch handshakes
- inst_rdata  out  32  fetch read data
- data_req / data_wr / data_size  in  1 / 1 / 2  data request, write flag, size (0 byte, 1 half, 2 word)
- data_addr / data_wdata  in  32 / 32  data address, store data
- data_addr_ok / data_data_ok  out  1 / 1  data handshakes
- data_rdata  out  32  load data
- mem_req / mem_wr / mem_size  out  1 / 1 / 2  to bridge
- mem_addr / mem_wdata  out  32 / 32  to bridge
- mem_addr_ok / mem_data_ok  in  1 / 1  bridge handshakes
- mem_rdata  in  32  bridge read data
- arb_busy  out  1  state != IDLE

## Operation
- States: IDLE, ADDR, WAIT. Registers: state, owner (0 inst, 1 data), discard, rr_last.
- IDLE: grant computed combinationally from inst_req/data_req; mem_* driven from granted master; granted master's addr_ok = mem_addr_ok. mem_addr_ok -> WAIT; else if mem_req -> ADDR. owner latched whenever mem_req=1.
- ADDR: mux locked to owner regardless of other request; owner's addr_ok = mem_addr_ok; on mem_addr_ok -> WAIT. Requester holds req/addr stable (protocol rule, not checked).
- WAIT: mem_req=0; both addr_ok=0. On mem_data_ok: owner's data_ok=1 unless suppressed; -> IDLE.
- rdata: inst_rdata = data_rdata = mem_rdata (unqualified; valid only with data_ok).
- Flush: owner=inst in ADDR or WAIT (or inst granted in IDLE) with flush_i=1 sets discard. In WAIT, inst_data_ok = mem_data_ok & ~discard & ~flush_i. discard clears on leaving WAIT. Flush never affects data-owner transactions (stores must complete).
- Non-owner handshakes are always 0.

## Timing
- Reset: state IDLE, owner 0, discard 0, rr_last 0 (inst); all outputs 0 while requesters are low.
- Address phase: zero-cycle pass-through; addr_ok same cycle as mem_addr_ok.
- Data phase: data_ok same cycle as mem_data_ok; new grant earliest the cycle after data_ok (one idle bubble min).
- mem_data_ok in IDLE/ADDR ignored (protocol error, no state change).
- Flush same cycle as inst data return: data suppressed, state -> IDLE.
- Reset mid-transaction: returns to IDLE; bridge reset together, no in-flight return expected.

## Configuration
- VIE_ARB_RR_EN defined: round-robin; on simultaneous requests in IDLE grant the master not in rr_last; rr_last updates at each address handshake.
- Undefined: fixed priority, data over inst; rr_last unused (removed).

## Structure
- Shared defines header: size encodings, owner encoding (VIE_ARB_INST/VIE_ARB_DATA), state encodings.
- One sub-module natural: vie_arb_grant (combinational grant selection incl. RR/fixed policy).

## Test plan
- Single inst read 0xBFC00000, mem_addr_ok cycle 0, mem_data_ok cycle 3 rdata 0x3C1D0000 -> inst_addr_ok cycle 0, inst_data_ok cycle 3, data 0x3C1D0000, state IDLE cycle 4.
- Simultaneous inst and data load, fixed priority -> data granted first, inst granted cycle after data_data_ok; with VIE_ARB_RR_EN and rr_last=data -> inst first.
- Data store (wr=1, size 2, wdata 0xDEADBEEF), mem_addr_ok delayed 4 cycles while inst_req rises -> grant stays data, mem_wdata stable, inst_addr_ok 0 throughout.
- Inst in WAIT, flush_i pulse, mem_data_ok 2 cycles later -> inst_data_ok 0, next fetch granted next cycle.
- Flush coinciding with mem_data_ok on data-owner load -> data_data_ok 1, data delivered.
- Reset asserted in WAIT -> IDLE next cycle, arb_busy 0, no data_ok emitted.
